i2c_eeprom_slave: RTL and testbench

- Synthesizable I2C slave that models a 24Cxx-style EEPROM.
- Sits directly downstream of the EEPROM I2C master on the I2C_SCLK / I2C_SDAT pair.
- Supports byte write, sequential write, current-address read, and random read (repeated START).
- Exposes write strobes and status so benches and the top level can check the master's transactions on hardware and in simulation.

---
 rtl/i2c_eeprom_slave_pkg.sv | 11 +
 rtl/i2c_line_sync.sv | 36 +++
 rtl/i2c_eeprom_slave.sv | 110 +++++++++++
 tb/tb_i2c_eeprom_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_eeprom_slave_pkg.sv
// i2c_eeprom_slave_pkg: shared state encoding and I2C protocol constants for the EEPROM slave.
package i2c_eeprom_slave_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_DEV, S_DEV_ACK, S_WORD, S_WORD_ACK,
      S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
   } state_t;
   localparam logic [6:0] DEF_DEV_ADDR = 7'h50;
   localparam int         RW_BIT       = 0;
   localparam logic       ACK          = 1'b0;
   localparam logic       NACK         = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: SCL/SDA synchronizers with edge, START and STOP detection.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);
   logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
   logic scl_s, scl_d, sda_d;
   // idle bus is high, so the chains reset to 1 to avoid a false edge after reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         scl_sr <= '1;
         sda_sr <= '1;
         scl_d  <= 1'b1;
         sda_d  <= 1'b1;
      end else begin
         scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl};
         sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda};
         scl_d  <= scl_s;
         sda_d  <= sda_s;
      end
   assign scl_s     = scl_sr[SYNC_STAGES-1];
   assign sda_s     = sda_sr[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: 24Cxx-style I2C EEPROM model with byte/sequential write and
// current/random read, exposing write strobes and pointer status.
module i2c_eeprom_slave
   import i2c_eeprom_slave_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
   parameter int         ADDR_W      = 4,
   parameter int         SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              I2C_SCLK,
   inout  wire               I2C_SDAT,
   output logic              MEM_WR_STB,
   output logic [ADDR_W-1:0] MEM_WR_ADDR,
   output logic [7:0]        MEM_WR_DATA,
   output logic              BUSY,
   output logic [ADDR_W-1:0] ADDR_PTR
);
   localparam int DEPTH = 2**ADDR_W;
   state_t state, state_nx;
   logic scl_rise, scl_fall, sda_s, start_det, stop_det;
   logic fall_d, sda_oe, drive_nx, rw;
   logic byte_done, dev_hit, wr_commit, rd_load, rd_nack;
   logic [2:0] bit_cnt;
   logic [7:0] sh, rx_byte;
   logic [7:0] mem [DEPTH];

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(CLK), .rst_n(RESET), .scl(I2C_SCLK), .sda(I2C_SDAT),
      .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_s(sda_s),
      .start_det(start_det), .stop_det(stop_det)
   );

   assign I2C_SDAT  = sda_oe ? 1'b0 : 1'bz;
   assign rx_byte   = {sh[6:0], sda_s};
   assign byte_done = scl_rise && bit_cnt == 3'd0;
   assign dev_hit   = rx_byte[7:1] == DEV_ADDR;
   // not gated by STOP so a byte completing with a STOP still commits
   assign wr_commit = state == S_WR && byte_done;
   assign rd_load   = scl_rise && ((state == S_DEV_ACK && rw) || (state == S_RD_ACK && sda_s == ACK));
   assign rd_nack   = scl_rise && state == S_RD_ACK && sda_s == NACK;

   always_comb begin
      state_nx = state;
      drive_nx = (state inside {S_DEV_ACK, S_WORD_ACK, S_WR_ACK}) ? 1'b1 :
                 (state == S_RD) ? ~sh[7] : 1'b0;
      if (stop_det)
         state_nx = S_IDLE;
      else if (start_det)
         state_nx = S_DEV;
      else if (scl_rise)
         case (state)
            S_DEV:                state_nx = byte_done ? (dev_hit ? S_DEV_ACK : S_IGNORE) : state;
            S_DEV_ACK:            state_nx = rw ? S_RD : S_WORD;
            S_WORD:               state_nx = byte_done ? S_WORD_ACK : state;
            S_WORD_ACK, S_WR_ACK: state_nx = S_WR;
            S_WR:                 state_nx = byte_done ? S_WR_ACK : state;
            S_RD:                 state_nx = byte_done ? S_RD_ACK : state;
            S_RD_ACK:             state_nx = sda_s == ACK ? S_RD : S_IGNORE;
            default:              state_nx = state;
         endcase
   end

   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) state <= S_IDLE;
      else        state <= state_nx;

   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         MEM_WR_STB  <= 1'b0;
         MEM_WR_ADDR <= '0;
         MEM_WR_DATA <= '0;
         BUSY        <= 1'b0;
         ADDR_PTR    <= '0;
         fall_d      <= 1'b0;
         sda_oe      <= 1'b0;
         rw          <= 1'b0;
         bit_cnt     <= 3'd7;
         sh          <= '0;
      end else begin
         MEM_WR_STB <= wr_commit;
         fall_d     <= scl_fall;
         if (start_det || stop_det)
            bit_cnt <= 3'd7;
         else if (scl_rise && state inside {S_DEV, S_WORD, S_WR, S_RD}) begin
            sh      <= rx_byte;
            bit_cnt <= bit_cnt - 1'b1;
         end
         if (rd_load) sh <= mem[ADDR_PTR];
         if (state == S_DEV && byte_done) rw <= rx_byte[RW_BIT];
         if (state == S_WORD && byte_done) ADDR_PTR <= rx_byte[ADDR_W-1:0];
         if (wr_commit || (state == S_RD && byte_done)) ADDR_PTR <= ADDR_PTR + 1'b1;
         if (wr_commit) begin
            mem[ADDR_PTR] <= rx_byte;
            MEM_WR_ADDR   <= ADDR_PTR;
            MEM_WR_DATA   <= rx_byte;
         end
         if (stop_det || rd_nack)
            BUSY <= 1'b0;
         else if (state == S_DEV && byte_done && dev_hit)
            BUSY <= 1'b1;
         // drive changes only one CLK after an SCL fall, so SDA is stable while SCL is high
         if (start_det || stop_det)
            sda_oe <= 1'b0;
         else if (fall_d)
            sda_oe <= drive_nx;
      end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: bit-banged I2C master with random transactions checked
// against a byte-array EEPROM model and expected write-strobe queue.
module tb_i2c_eeprom_slave;
   localparam int Q = 50;
   logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_sda = 1'b1;
   wire  sda;
   logic stb, busy;
   logic [3:0] wr_addr, ptr;
   logic [7:0] wr_data;
   int n_vec = 0, n_err = 0;
   int ptr_m = 0;
   logic [7:0] mem_m [16];
   logic [11:0] stb_q[$], exp_q[$];
   logic [7:0] wq[$];
   logic [11:0] last_wr = '0;
   bit slave_low = 0, prev_s = 0, prev_scl = 1;
   int hi_viol = 0;

   assign sda = m_sda ? 1'bz : 1'b0;
   pullup (sda);

   i2c_eeprom_slave dut (
      .CLK(clk), .RESET(rst_n), .I2C_SCLK(scl), .I2C_SDAT(sda),
      .MEM_WR_STB(stb), .MEM_WR_ADDR(wr_addr), .MEM_WR_DATA(wr_data),
      .BUSY(busy), .ADDR_PTR(ptr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      bit s;
      s = m_sda && sda === 1'b0;
      if (s) slave_low = 1;
      if (scl && prev_scl && s && !prev_s) hi_viol++;
      prev_s   = s;
      prev_scl = scl;
      if (stb) stb_q.push_back({wr_addr, wr_data});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_c();
      #Q m_sda = 1'b1; #Q scl = 1'b1; #Q m_sda = 1'b0; #Q scl = 1'b0;
   endtask

   task automatic stop_c();
      #Q m_sda = 1'b0; #Q scl = 1'b1; #Q m_sda = 1'b1; #Q;
   endtask

   task automatic write_bit(input logic b);
      #Q m_sda = b; #Q scl = 1'b1; #(2*Q) scl = 1'b0;
   endtask

   task automatic read_bit(output logic b);
      #Q m_sda = 1'b1; #Q scl = 1'b1; #Q b = sda; #Q scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(ack);
   endtask

   task automatic recv_byte(output logic [7:0] v, input logic last);
      for (int i = 7; i >= 0; i--) read_bit(v[i]);
      write_bit(last);
   endtask

   task automatic cmp_stb();
      check("stb_count", stb_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++) check("stb_entry", stb_q[i], exp_q[i]);
      stb_q.delete();
      exp_q.delete();
   endtask

   task automatic wr_txn(input logic [7:0] wa);
      logic a;
      start_c();
      send_byte(8'hA0, a); check("dev_ack", a, 0);
      check("busy_on", busy, 1);
      send_byte(wa, a); check("word_ack", a, 0);
      ptr_m = wa % 16;
      foreach (wq[i]) begin
         send_byte(wq[i], a); check("data_ack", a, 0);
         mem_m[ptr_m] = wq[i];
         last_wr = {4'(ptr_m), wq[i]};
         exp_q.push_back(last_wr);
         ptr_m = (ptr_m + 1) % 16;
      end
      stop_c();
      #200;
      check("busy_off_wr", busy, 0);
      check("ptr_wr", ptr, ptr_m);
      check("wr_hold", {wr_addr, wr_data}, last_wr);
      cmp_stb();
   endtask

   task automatic rd_txn(input logic [7:0] wa, input bit rnd, input int n);
      logic a;
      logic [7:0] d;
      if (rnd) begin
         start_c();
         send_byte(8'hA0, a); check("rd_dev_ack", a, 0);
         send_byte(wa, a); check("rd_word_ack", a, 0);
         ptr_m = wa % 16;
      end
      start_c();
      send_byte(8'hA1, a); check("rd_ctl_ack", a, 0);
      for (int i = 0; i < n; i++) begin
         recv_byte(d, i == n - 1);
         check("rd_data", d, mem_m[ptr_m]);
         ptr_m = (ptr_m + 1) % 16;
      end
      stop_c();
      #200;
      check("busy_off_rd", busy, 0);
      check("ptr_rd", ptr, ptr_m);
      cmp_stb();
   endtask

   task automatic chk_reset_outs();
      check("rst_sda", sda, 1);
      check("rst_busy", busy, 0);
      check("rst_stb", stb, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_ptr", ptr, 0);
   endtask

   initial begin
      logic a;
      logic [7:0] v;
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      #2;
      chk_reset_outs();
      #100 rst_n = 1'b1;
      #100;
      // byte write then random read of the same location
      wq = '{8'h55};
      wr_txn(8'h03);
      rd_txn(8'h03, 1, 1);
      check("ptr_after_rr", ptr, 4);
      // non-matching device address
      slave_low = 0;
      start_c();
      send_byte(8'hA2, a); check("wrong_nack", a, 1);
      send_byte(8'h03, a); check("wrong_nack2", a, 1);
      check("wrong_busy", busy, 0);
      stop_c();
      #200;
      check("wrong_no_drive", slave_low, 0);
      cmp_stb();
      // wrap at top of memory
      wq = '{8'hAA, 8'hBB};
      wr_txn(8'h0F);
      check("wrap_ptr", ptr, 1);
      // abort after 5 data bits
      start_c();
      send_byte(8'hA0, a); check("ab_dev_ack", a, 0);
      send_byte(8'h07, a); check("ab_word_ack", a, 0);
      ptr_m = 7;
      v = 8'($urandom);
      for (int i = 7; i >= 3; i--) write_bit(v[i]);
      stop_c();
      #200;
      check("abort_busy", busy, 0);
      check("abort_ptr", ptr, 7);
      cmp_stb();
      rd_txn(8'h00, 0, 1);
      // random traffic
      for (int t = 0; t < 24; t++) begin
         int op;
         op = $urandom_range(0, 2);
         if (op == 0) begin
            wq.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) wq.push_back(8'($urandom));
            wr_txn(8'($urandom));
         end else
            rd_txn(8'($urandom), op == 1, $urandom_range(1, 4));
      end
      // reset while the slave is driving a 0 data bit
      wq = '{8'h15};
      wr_txn(8'h05);
      start_c();
      send_byte(8'hA0, a); check("rr_dev_ack", a, 0);
      send_byte(8'h05, a); check("rr_word_ack", a, 0);
      start_c();
      send_byte(8'hA1, a); check("rr_ctl_ack", a, 0);
      #70;
      check("rd_bit_drive", sda, 0);
      rst_n = 1'b0;
      #1;
      chk_reset_outs();
      #9 m_sda = 1'b1; scl = 1'b1;
      #50 rst_n = 1'b1;
      #100;
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      ptr_m = 0;
      stb_q.delete();
      exp_q.delete();
      wq = '{8'hC3, 8'h3C};
      wr_txn(8'h09);
      rd_txn(8'h09, 1, 2);
      rd_txn(8'h05, 1, 1);
      check("hi_drive", hi_viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
